// File: rtl/rv_regfile_mp.sv
// ============================================================================
//  Module      : rv_regfile_mp
//  Description : Multi-port integer register file with two prioritised write
//                ports, optional r0 hardwiring, write bypass and busy scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_regfile_mp #(
    parameter int XLEN    = 32,
    parameter int NREGS   = 32,
    parameter int AW      = 5,
    parameter int NRD     = 2,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*XLEN-1:0]  rd_data,
    output logic [NRD-1:0]       rd_busy,
    input  logic                 wr0_en,
    input  logic [AW-1:0]        wr0_addr,
    input  logic [XLEN-1:0]      wr0_data,
    input  logic                 wr1_en,
    input  logic [AW-1:0]        wr1_addr,
    input  logic [XLEN-1:0]      wr1_data,
    input  logic                 iss_en,
    input  logic [AW-1:0]        iss_addr,
    output logic [NREGS-1:0]     busy_vec
);

    localparam bit c_zeroR0 = (ZERO_R0 != 0);
    localparam bit c_bypass = (BYPASS != 0);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busyNext;
    logic             w_wr0Ok;
    logic             w_wr1Ok;

    assign w_wr0Ok  = wr0_en && !(c_zeroR0 && (wr0_addr == '0));
    assign w_wr1Ok  = wr1_en && !(c_zeroR0 && (wr1_addr == '0));
    assign busy_vec = r_busy;

    // Issue is applied after writeback clears so a new producer keeps the bit set.
    always_comb begin
        w_busyNext = r_busy;
        for (int i = 0; i < NREGS; i++) begin
            if ((wr0_en && (wr0_addr == AW'(i))) || (wr1_en && (wr1_addr == AW'(i))))
                w_busyNext[i] = 1'b0;
            if (iss_en && (iss_addr == AW'(i)))
                w_busyNext[i] = 1'b1;
        end
        if (c_zeroR0)
            w_busyNext[0] = 1'b0;
    end

    // Port 1 is assigned last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                r_regs[i] <= '0;
            r_busy <= '0;
        end else begin
            if (w_wr0Ok)
                r_regs[wr0_addr] <= wr0_data;
            if (w_wr1Ok)
                r_regs[wr1_addr] <= wr1_data;
            r_busy <= w_busyNext;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rdPort
        logic [AW-1:0] w_addr;
        logic          w_hit0;
        logic          w_hit1;
        logic          w_zero;

        assign w_addr = rd_addr[p*AW +: AW];
        assign w_zero = c_zeroR0 && (w_addr == '0);
        assign w_hit1 = c_bypass && !rst && wr1_en && (wr1_addr == w_addr);
        assign w_hit0 = c_bypass && !rst && wr0_en && (wr0_addr == w_addr);

        assign rd_data[p*XLEN +: XLEN] = w_zero ? '0 :
                                         w_hit1 ? wr1_data :
                                         w_hit0 ? wr0_data :
                                         r_regs[w_addr];
        // A value arriving this cycle is already forwarded, so the consumer need not stall.
        assign rd_busy[p] = r_busy[w_addr] && !(w_hit0 || w_hit1);
    end

endmodule

`default_nettype wire

// File: tb/tb_rv_regfile_mp.sv
// ============================================================================
//  Module      : tb_rv_regfile_mp
//  Description : Self-checking bench for rv_regfile_mp (two configurations).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rdAddr;
    logic        wr0En, wr1En, issEn;
    logic [4:0]  wr0Addr, wr1Addr, issAddr;
    logic [31:0] wr0Data, wr1Data;
    logic [63:0] rdDataA, rdDataB;
    logic [1:0]  rdBusyA, rdBusyB;
    logic [31:0] busyVecA, busyVecB;

    int checks = 0;
    int errors = 0;

    // Reference state: index 0 = ZERO_R0=1/BYPASS=1, index 1 = ZERO_R0=0/BYPASS=0
    logic [31:0] mReg [2][32];
    logic [31:0] mBusy [2];

    always #5 clk = ~clk;

    rv_regfile_mp #(.XLEN(32), .NREGS(32), .AW(5), .NRD(2), .ZERO_R0(1), .BYPASS(1)) dutA (
        .clk(clk), .rst(rst), .rd_addr(rdAddr), .rd_data(rdDataA), .rd_busy(rdBusyA),
        .wr0_en(wr0En), .wr0_addr(wr0Addr), .wr0_data(wr0Data),
        .wr1_en(wr1En), .wr1_addr(wr1Addr), .wr1_data(wr1Data),
        .iss_en(issEn), .iss_addr(issAddr), .busy_vec(busyVecA)
    );

    rv_regfile_mp #(.XLEN(32), .NREGS(32), .AW(5), .NRD(2), .ZERO_R0(0), .BYPASS(0)) dutB (
        .clk(clk), .rst(rst), .rd_addr(rdAddr), .rd_data(rdDataB), .rd_busy(rdBusyB),
        .wr0_en(wr0En), .wr0_addr(wr0Addr), .wr0_data(wr0Data),
        .wr1_en(wr1En), .wr1_addr(wr1Addr), .wr1_data(wr1Data),
        .iss_en(issEn), .iss_addr(issAddr), .busy_vec(busyVecB)
    );

    typedef struct {
        logic        rst;
        logic        w0e;
        logic [4:0]  w0a;
        logic [31:0] w0d;
        logic        w1e;
        logic [4:0]  w1a;
        logic [31:0] w1d;
        logic        ie;
        logic [4:0]  ia;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] eD0;
        logic [31:0] eD1;
        logic [1:0]  eRB;
        logic [31:0] eBV;
        logic [31:0] eNb;
    } vec_t;

    vec_t vecs [17];

    function automatic vec_t mk(input int r, input int w0e, input int w0a, input bit [31:0] w0d,
                                input int w1e, input int w1a, input bit [31:0] w1d,
                                input int ie, input int ia, input int ra0, input int ra1,
                                input bit [31:0] eD0, input bit [31:0] eD1, input int eRB,
                                input bit [31:0] eBV, input bit [31:0] eNb);
        vec_t v;
        v.rst = r[0];   v.w0e = w0e[0]; v.w0a = w0a[4:0]; v.w0d = w0d;
        v.w1e = w1e[0]; v.w1a = w1a[4:0]; v.w1d = w1d;
        v.ie  = ie[0];  v.ia  = ia[4:0];  v.ra0 = ra0[4:0]; v.ra1 = ra1[4:0];
        v.eD0 = eD0;    v.eD1 = eD1;      v.eRB = eRB[1:0]; v.eBV = eBV; v.eNb = eNb;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic driveVec(input vec_t v);
        rst = v.rst;
        wr0En = v.w0e; wr0Addr = v.w0a; wr0Data = v.w0d;
        wr1En = v.w1e; wr1Addr = v.w1a; wr1Data = v.w1d;
        issEn = v.ie;  issAddr = v.ia;
        rdAddr = {v.ra1, v.ra0};
    endtask

    function automatic logic [31:0] expData(input int c, input logic [4:0] a);
        bit z = (c == 0);
        bit b = (c == 0);
        if (z && a == 5'd0) return 32'd0;
        if (b && !rst && wr1En && wr1Addr == a) return wr1Data;
        if (b && !rst && wr0En && wr0Addr == a) return wr0Data;
        return mReg[c][a];
    endfunction

    function automatic logic expBusy(input int c, input logic [4:0] a);
        bit b = (c == 0);
        if (b && !rst && ((wr0En && wr0Addr == a) || (wr1En && wr1Addr == a))) return 1'b0;
        return mBusy[c][a];
    endfunction

    task automatic modelCheck(input string tag);
        for (int c = 0; c < 2; c++) begin
            for (int p = 0; p < 2; p++) begin
                logic [4:0]  a;
                logic [31:0] d;
                logic        bz;
                a  = rdAddr[p*5 +: 5];
                d  = (c == 0) ? rdDataA[p*32 +: 32] : rdDataB[p*32 +: 32];
                bz = (c == 0) ? rdBusyA[p] : rdBusyB[p];
                check($sformatf("%s cfg%0d p%0d data", tag, c, p), d, expData(c, a));
                check($sformatf("%s cfg%0d p%0d busy", tag, c, p), {31'd0, bz}, {31'd0, expBusy(c, a)});
            end
            check($sformatf("%s cfg%0d busyvec", tag, c), (c == 0) ? busyVecA : busyVecB, mBusy[c]);
        end
    endtask

    task automatic modelEdge();
        for (int c = 0; c < 2; c++) begin
            if (rst) begin
                for (int i = 0; i < 32; i++) mReg[c][i] = 32'd0;
                mBusy[c] = 32'd0;
            end else begin
                if (wr0En && !(c == 0 && wr0Addr == 5'd0)) mReg[c][wr0Addr] = wr0Data;
                if (wr1En && !(c == 0 && wr1Addr == 5'd0)) mReg[c][wr1Addr] = wr1Data;
                if (wr0En) mBusy[c][wr0Addr] = 1'b0;
                if (wr1En) mBusy[c][wr1Addr] = 1'b0;
                if (issEn) mBusy[c][issAddr] = 1'b1;
                if (c == 0) mBusy[c][0] = 1'b0;
            end
        end
    endtask

    function automatic logic [4:0] randAddr();
        logic [31:0] r;
        r = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7);
        return r[4:0];
    endfunction

    initial begin
        //                 rst w0e w0a w0d            w1e w1a w1d     ie ia ra0 ra1 eD0            eD1            eRB eBV     eNb
        vecs[0]  = mk(1, 1, 5, 32'hAA,       0, 0, 32'h0,  0, 0, 5, 0, 32'h0,        32'h0,        0, 32'h0,   32'h0);
        vecs[1]  = mk(0, 1, 5, 32'hDEADBEEF, 0, 0, 32'h0,  0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 32'h0,   32'h0);
        vecs[2]  = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 0, 5, 32'h0,        32'hDEADBEEF, 0, 32'h0,   32'h0);
        vecs[3]  = mk(0, 1, 7, 32'h11,       1, 7, 32'h22, 0, 0, 7, 0, 32'h22,       32'h0,        0, 32'h0,   32'h0);
        vecs[4]  = mk(0, 0, 0, 32'h0,        1, 0, 32'hFF, 0, 0, 0, 7, 32'h0,        32'h22,       0, 32'h0,   32'h0);
        vecs[5]  = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,  1, 3, 3, 0, 32'h0,        32'h0,        0, 32'h8,   32'h0);
        vecs[6]  = mk(0, 1, 3, 32'h33,       0, 0, 32'h0,  1, 3, 3, 3, 32'h33,       32'h33,       0, 32'h8,   32'h0);
        vecs[7]  = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 3, 5, 32'h33,       32'hDEADBEEF, 1, 32'h8,   32'h33);
        vecs[8]  = mk(0, 1, 3, 32'h34,       0, 0, 32'h0,  0, 0, 0, 3, 32'h0,        32'h34,       0, 32'h0,   32'hFF);
        vecs[9]  = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,  1, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,   32'hFF);
        vecs[10] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,  1, 9, 9, 9, 32'h0,        32'h0,        0, 32'h200, 32'h0);
        vecs[11] = mk(0, 0, 0, 32'h0,        1, 9, 32'h55, 0, 0, 9, 7, 32'h55,       32'h22,       0, 32'h0,   32'h0);
        vecs[12] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,  1, 9, 9, 5, 32'h55,       32'hDEADBEEF, 0, 32'h200, 32'h55);
        vecs[13] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,  1, 4, 4, 9, 32'h0,        32'h55,       2, 32'h210, 32'h0);
        vecs[14] = mk(1, 1, 5, 32'h99,       0, 0, 32'h0,  1, 6, 5, 9, 32'hDEADBEEF, 32'h55,       2, 32'h0,   32'hDEADBEEF);
        vecs[15] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 5, 9, 32'h0,        32'h0,        0, 32'h0,   32'h0);
        vecs[16] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,  1, 6, 6, 4, 32'h0,        32'h0,        0, 32'h40,  32'h0);

        rst = 1'b1; wr0En = 1'b0; wr1En = 1'b0; issEn = 1'b0;
        wr0Addr = '0; wr1Addr = '0; issAddr = '0; wr0Data = '0; wr1Data = '0; rdAddr = '0;
        repeat (2) begin
            @(posedge clk);
            modelEdge();
        end
        #1 rst = 1'b0;

        @(negedge clk);
        check("reset busyvecA", busyVecA, 32'h0);
        check("reset busyvecB", busyVecB, 32'h0);
        for (int i = 0; i < 32; i++) begin
            logic [4:0] a;
            a = 5'(i);
            rdAddr = {a, a};
            @(negedge clk);
            check($sformatf("reset r%0d A p0", i), rdDataA[31:0],  32'h0);
            check($sformatf("reset r%0d A p1", i), rdDataA[63:32], 32'h0);
            check($sformatf("reset r%0d B p0", i), rdDataB[31:0],  32'h0);
            check($sformatf("reset r%0d B p1", i), rdDataB[63:32], 32'h0);
        end
        @(posedge clk);
        #1;

        for (int k = 0; k < 17; k++) begin
            driveVec(vecs[k]);
            @(negedge clk);
            modelCheck($sformatf("v%0d", k));
            check($sformatf("v%0d A rd0", k), rdDataA[31:0],  vecs[k].eD0);
            check($sformatf("v%0d A rd1", k), rdDataA[63:32], vecs[k].eD1);
            check($sformatf("v%0d A rdbusy", k), {30'd0, rdBusyA}, {30'd0, vecs[k].eRB});
            check($sformatf("v%0d B rd0", k), rdDataB[31:0],  vecs[k].eNb);
            @(posedge clk);
            modelEdge();
            #1;
            check($sformatf("v%0d A busyvec", k), busyVecA, vecs[k].eBV);
        end

        for (int n = 0; n < 600; n++) begin
            vec_t v;
            v = vecs[0];
            v.rst = ($urandom_range(0, 39) == 0);
            v.w0e = $urandom_range(0, 1) == 1; v.w0a = randAddr(); v.w0d = $urandom;
            v.w1e = $urandom_range(0, 2) == 0; v.w1a = randAddr(); v.w1d = $urandom;
            v.ie  = $urandom_range(0, 1) == 1; v.ia  = randAddr();
            v.ra0 = randAddr(); v.ra1 = randAddr();
            driveVec(v);
            @(negedge clk);
            modelCheck($sformatf("rnd%0d", n));
            @(posedge clk);
            modelEdge();
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
